// File: rtl/mul_share_ctrl.sv
// Round-robin controller sharing one shift-add multiplier among N_REQ requesters.
// Zero operands bypass the multiplier; a watchdog aborts a hung WAIT.
module mul_share_ctrl #(
  parameter int N_REQ       = 4,
  parameter int LOAD_CYCLES = 2,
  parameter int TIMEOUT     = 80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [32*N_REQ-1:0] op_a,
  input  logic [32*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]   ack,
  output logic [63:0]        result,
  output logic               result_valid,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               err,
  output logic               mul_load,
  output logic [31:0]        mul_cand,
  output logic [31:0]        mul_er,
  input  logic               mul_done,
  input  logic [63:0]        mul_product
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [2:0]         r_ptr;
  logic [2:0]         r_grant;
  logic [3:0]         r_lcnt;
  logic [WW-1:0]      r_wcnt;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [N_REQ-1:0]   r_ack;
  logic [63:0]        r_result;
  logic               r_rv;
  logic               r_err;
  logic               r_load;

  logic               w_any;
  logic [2:0]         w_win;
  logic [IW-1:0]      w_idx;
  logic [31:0]        w_a;
  logic [31:0]        w_b;
  logic               w_zero;

  // Search starts one past the last winner so it ranks last next time.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    w_a   = '0;
    w_b   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = IW'((int'(r_ptr) + i) % N_REQ);
      if (!w_any && req[w_idx]) begin
        w_any = 1'b1;
        w_win = 3'(w_idx);
        w_a   = op_a[{w_idx, 5'd0} +: 32];
        w_b   = op_b[{w_idx, 5'd0} +: 32];
      end
    end
  end

  assign w_zero = (w_a == '0) || (w_b == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ptr    <= 3'(N_REQ - 1);
      r_grant  <= '0;
      r_lcnt   <= '0;
      r_wcnt   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_ack    <= '0;
      r_result <= '0;
      r_rv     <= 1'b0;
      r_err    <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_ack <= '0;
      r_rv  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_win;
            r_a     <= w_a;
            r_b     <= w_b;
            if (w_zero) begin
              r_result <= '0;
              r_ack    <= ONE << w_win;
              r_rv     <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_load  <= 1'b1;
              r_lcnt  <= '0;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (r_lcnt == 4'(LOAD_CYCLES - 1)) begin
            r_load  <= 1'b0;
            r_wcnt  <= '0;
            r_state <= S_WAIT;
          end else begin
            r_lcnt <= r_lcnt + 4'd1;
          end
        end
        S_WAIT: begin
          // First WAIT cycle may still see the previous op's done.
          if (r_wcnt != '0 && mul_done) begin
            r_result <= mul_product;
            r_ack    <= ONE << r_grant;
            r_rv     <= 1'b1;
            r_state  <= S_DONE;
          end else if (r_wcnt == WW'(TIMEOUT - 1)) begin
            r_err    <= 1'b1;
            r_result <= '0;
            r_ack    <= ONE << r_grant;
            r_rv     <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_wcnt <= r_wcnt + WW'(1);
          end
        end
        S_DONE: begin
          r_ptr   <= r_grant;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack          = r_ack;
  assign result       = r_result;
  assign result_valid = r_rv;
  assign grant_id     = r_grant;
  assign busy         = (r_state != S_IDLE);
  assign err          = r_err;
  assign mul_load     = r_load;
  assign mul_cand     = r_a;
  assign mul_er       = r_b;

endmodule
